toggle_event_decoder: RTL and testbench

//   Receive-side decoder for a toggle-encoded event line. A T flip-flop elsewhere turns

---
 rtl/toggle_event_decoder.sv | 138 +++++++++++++
 tb/tb_toggle_event_decoder.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/toggle_event_decoder.sv
// toggle_event_decoder
//   Receive side of a toggle-encoded event line. A remote T flip-flop turns
//   event pulses into level changes. This block turns them back into events:
//   - synchronises t_in into the c clock domain,
//   - emits a one-cycle pulse for each level change,
//   - counts unconsumed events in a saturating counter,
//   - hands the count to a consumer over a valid/ready handshake.
//
// Ports
//   c         in   clock, rising edge
//   rst       in   asynchronous active-high reset
//   t_in      in   toggle line, asynchronous to c
//   ev_pulse  out  one-cycle pulse per detected toggle
//   q         out  synchronised level of t_in
//   q1        out  complement of q
//   ev_valid  out  one or more events are pending
//   ev_ready  in   consumer accepts ev_count this cycle
//   ev_count  out  number of pending events, valid while ev_valid=1
//   overflow  out  sticky flag, an event was lost to saturation
//   ovf_clr   in   synchronous clear for overflow
module toggle_event_decoder #(
  parameter int   SYNC_STAGES = 2,
  parameter int   CNT_W       = 8,
  parameter logic INIT_LVL    = 1'b1
) (
  input  logic             c,
  input  logic             rst,
  input  logic             t_in,
  output logic             ev_pulse,
  output logic             q,
  output logic             q1,
  output logic             ev_valid,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] ev_count,
  output logic             overflow,
  input  logic             ovf_clr
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    PEND = 1'b1
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync;
  logic                   last_lvl;
  logic                   tog;
  logic                   acc;
  logic                   at_max;

  // Synchroniser chain. q1 is kept as its own flop (fed from the stage
  // before q) so that both level outputs come straight from registers.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      sync <= {SYNC_STAGES{INIT_LVL}};
      q1   <= ~INIT_LVL;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], t_in};
      q1   <= ~sync[SYNC_STAGES-2];
    end
  end

  assign q = sync[SYNC_STAGES-1];

  // Edge detect, handshake accept and saturation condition.
  always_comb begin
    tog    = q ^ last_lvl;
    acc    = ev_valid & ev_ready;
    at_max = (ev_count == CNT_MAX);
  end

  // Event FSM: pulse generation, pending counter, valid flag and sticky overflow.
  // ev_count is the pending-event register itself.
  always_ff @(posedge c or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      last_lvl <= INIT_LVL;
      ev_pulse <= 1'b0;
      ev_count <= '0;
      ev_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      last_lvl <= q;
      ev_pulse <= tog;

      // A new overflow beats a simultaneous clear.
      if (tog && !acc && at_max) begin
        overflow <= 1'b1;
      end else if (ovf_clr) begin
        overflow <= 1'b0;
      end else begin
        overflow <= overflow;
      end

      case (state)
        IDLE: begin
          if (tog) begin
            state    <= PEND;
            ev_count <= CNT_ONE;
            ev_valid <= 1'b1;
          end else begin
            state    <= IDLE;
            ev_count <= '0;
            ev_valid <= 1'b0;
          end
        end
        PEND: begin
          if (acc) begin
            // The consumer took the old count on this edge; an event arriving
            // on the same edge becomes the first of the next batch.
            if (tog) begin
              state    <= PEND;
              ev_count <= CNT_ONE;
              ev_valid <= 1'b1;
            end else begin
              state    <= IDLE;
              ev_count <= '0;
              ev_valid <= 1'b0;
            end
          end else if (tog && !at_max) begin
            ev_count <= ev_count + CNT_ONE;
          end else begin
            ev_count <= ev_count;
          end
        end
        default: begin
          state    <= IDLE;
          ev_count <= '0;
          ev_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_toggle_event_decoder.sv
// Testbench for toggle_event_decoder (SYNC_STAGES=2, CNT_W=3).
// Each toggle driven on t_in pushes the cycle at which its ev_pulse is
// expected; a monitor pops and compares when the DUT pulses. Counter,
// handshake and flag values are checked at directed points.
module tb_toggle_event_decoder;

  logic       c = 1'b0;
  logic       rst;
  logic       t_in;
  logic       ev_pulse;
  logic       q;
  logic       q1;
  logic       ev_valid;
  logic       ev_ready;
  logic [2:0] ev_count;
  logic       overflow;
  logic       ovf_clr;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_q[$];

  toggle_event_decoder #(
    .SYNC_STAGES(2),
    .CNT_W(3),
    .INIT_LVL(1'b1)
  ) dut (
    .c(c),
    .rst(rst),
    .t_in(t_in),
    .ev_pulse(ev_pulse),
    .q(q),
    .q1(q1),
    .ev_valid(ev_valid),
    .ev_ready(ev_ready),
    .ev_count(ev_count),
    .overflow(overflow),
    .ovf_clr(ovf_clr)
  );

  always #5 c = ~c;

  always @(posedge c) cyc <= cyc + 1;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Pulse monitor: every pulse must match the oldest expected cycle.
  always @(negedge c) begin
    if (!rst) begin
      if (exp_q.size() != 0 && exp_q[0] < cyc) begin
        chk("pulse_missing_at", exp_q[0], -1);
        void'(exp_q.pop_front());
      end
      if (ev_pulse) begin
        if (exp_q.size() == 0) begin
          chk("pulse_unexpected_at", cyc, -1);
        end else begin
          chk("pulse_cycle", cyc, exp_q.pop_front());
        end
      end
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge c);
  endtask

  // Called at a negedge: pulse expected 3 edges later (2 sync + 1 register).
  task automatic toggle();
    t_in = ~t_in;
    exp_q.push_back(cyc + 3);
  endtask

  task automatic accept();
    ev_ready = 1'b1;
    wait_cyc(1);
    ev_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    t_in = 1'b1;
    ev_ready = 1'b0;
    ovf_clr = 1'b0;
    wait_cyc(3);
    rst = 1'b0;
    wait_cyc(1);

    // 1: reset state, no pulses while t_in holds its reset level
    chk("rst_q", q, 1);
    chk("rst_q1", q1, 0);
    chk("rst_valid", ev_valid, 0);
    chk("rst_count", ev_count, 0);
    chk("rst_ovf", overflow, 0);
    chk("rst_pulse", ev_pulse, 0);
    wait_cyc(20);
    chk("idle_valid", ev_valid, 0);
    chk("idle_q", q, 1);

    // 2: single toggle, then accept
    toggle();
    wait_cyc(3);
    chk("t2_pulse", ev_pulse, 1);
    chk("t2_valid", ev_valid, 1);
    chk("t2_count", ev_count, 1);
    chk("t2_q", q, 0);
    chk("t2_q1", q1, 1);
    wait_cyc(1);
    accept();
    chk("t2_valid_after_acc", ev_valid, 0);
    chk("t2_count_after_acc", ev_count, 0);

    // 3: five toggles accumulate, one accept drains
    for (int i = 0; i < 5; i++) begin
      toggle();
      wait_cyc(4);
    end
    chk("t3_count", ev_count, 5);
    chk("t3_valid", ev_valid, 1);
    accept();
    chk("t3_count_drained", ev_count, 0);
    chk("t3_valid_drained", ev_valid, 0);

    // 4: accept on the same edge as a new toggle
    for (int i = 0; i < 3; i++) begin
      toggle();
      wait_cyc(4);
    end
    chk("t4_count_before", ev_count, 3);
    toggle();
    wait_cyc(2);
    chk("t4_count_transferred", ev_count, 3);
    ev_ready = 1'b1;
    wait_cyc(1);
    ev_ready = 1'b0;
    chk("t4_count_after", ev_count, 1);
    chk("t4_valid_after", ev_valid, 1);
    wait_cyc(3);
    accept();
    chk("t4_drained", ev_count, 0);

    // 5: saturation and overflow
    for (int i = 0; i < 7; i++) begin
      toggle();
      wait_cyc(4);
    end
    chk("t5_count_at_max", ev_count, 7);
    chk("t5_ovf_not_yet", overflow, 0);
    for (int i = 0; i < 2; i++) begin
      toggle();
      wait_cyc(4);
    end
    chk("t5_count_sat", ev_count, 7);
    chk("t5_ovf_set", overflow, 1);
    ovf_clr = 1'b1;
    wait_cyc(1);
    ovf_clr = 1'b0;
    chk("t5_ovf_cleared", overflow, 0);
    chk("t5_count_kept", ev_count, 7);
    // clear and new overflow on the same edge: set wins
    toggle();
    wait_cyc(2);
    ovf_clr = 1'b1;
    wait_cyc(1);
    ovf_clr = 1'b0;
    chk("t5_ovf_set_wins", overflow, 1);
    chk("t5_count_still_max", ev_count, 7);
    wait_cyc(3);
    accept();
    chk("t5_drained", ev_count, 0);
    chk("t5_ovf_sticky", overflow, 1);
    ovf_clr = 1'b1;
    wait_cyc(1);
    ovf_clr = 1'b0;

    // 6: reset mid-operation with t_in away from its reset level
    toggle();
    wait_cyc(4);
    accept();
    for (int i = 0; i < 4; i++) begin
      toggle();
      wait_cyc(4);
    end
    chk("t6_count_before", ev_count, 4);
    chk("t6_tin_low", q, 0);
    rst = 1'b1;
    #1;
    chk("t6_rst_count", ev_count, 0);
    chk("t6_rst_valid", ev_valid, 0);
    chk("t6_rst_pulse", ev_pulse, 0);
    chk("t6_rst_ovf", overflow, 0);
    chk("t6_rst_q", q, 1);
    chk("t6_rst_q1", q1, 0);
    wait_cyc(2);
    rst = 1'b0;
    exp_q.push_back(cyc + 3);
    wait_cyc(3);
    chk("t6_pulse", ev_pulse, 1);
    chk("t6_count", ev_count, 1);
    chk("t6_valid", ev_valid, 1);

    wait_cyc(5);
    chk("pulses_outstanding", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
